// File: rtl/router_fsm_n.sv
`default_nettype none
// ============================================================================
// Module      : router_fsm_n
// Description : Packet router control FSM. It decodes the header address,
//               sequences the register-block writes, stalls on a full FIFO,
//               waits for an occupied FIFO to drain, drops bad packets and
//               counts completed packets.
// Revision    : 1.0 - initial release
// ============================================================================
module router_fsm_n #(
    parameter int DATA_W   = 8,
    parameter int NUM_CH   = 3,
    parameter int ADDR_W   = 2,
    parameter int WAIT_MAX = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] din,
    input  logic              fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] soft_rst,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              drop_state,
    output logic              wr_en_reg,
    output logic              rst_in_reg,
    output logic              busy,
    output logic [ADDR_W-1:0] addr_q,
    output logic              wait_timeout,
    output logic [15:0]       pkt_count
);

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        FIFO_FULL_STATE    = 4'd3,
        LOAD_AFTER_FULL    = 4'd4,
        LOAD_PARITY        = 4'd5,
        CHECK_PARITY_ERROR = 4'd6,
        WAIT_TILL_EMPTY    = 4'd7,
        DROP_PACKET        = 4'd8
    } state_t;

    localparam logic [7:0] c_WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_wait_cnt;
    logic [ADDR_W-1:0] w_din_addr;
    logic              w_addr_ok;
    logic              w_din_empty;
    logic              w_cur_empty;
    logic              w_soft_hit;
    logic              w_timeout;
    logic              w_pkt_done;
    logic              w_unused_din;

    assign w_din_addr   = din[ADDR_W-1:0];
    assign w_addr_ok    = int'(w_din_addr) < NUM_CH;
    assign w_unused_din = ^din[DATA_W-1:ADDR_W];

    // Out-of-range addresses select nothing, so they read as not-empty / no soft reset.
    always_comb begin
        w_din_empty = 1'b0;
        w_cur_empty = 1'b0;
        w_soft_hit  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_din_addr == ADDR_W'(i)) begin
                w_din_empty = fifo_empty[i];
            end
            if (addr_q == ADDR_W'(i)) begin
                w_cur_empty = fifo_empty[i];
                w_soft_hit  = soft_rst[i];
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_timeout  = 1'b0;
        w_pkt_done = 1'b0;
        case (r_state)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if (!w_addr_ok)       w_next = DROP_PACKET;
                    else if (w_din_empty) w_next = LOAD_FIRST_DATA;
                    else                  w_next = WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: w_next = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       w_next = FIFO_FULL_STATE;
                else if (!pkt_valid) w_next = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) w_next = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    w_next     = DECODE_ADDRESS;
                    w_pkt_done = 1'b1;
                end else if (low_pkt_valid) begin
                    w_next = LOAD_PARITY;
                end else begin
                    w_next = LOAD_DATA;
                end
            end
            LOAD_PARITY: w_next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                if (fifo_full) begin
                    w_next = FIFO_FULL_STATE;
                end else begin
                    w_next     = DECODE_ADDRESS;
                    w_pkt_done = 1'b1;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (w_cur_empty) begin
                    w_next = LOAD_FIRST_DATA;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_next    = DROP_PACKET;
                    w_timeout = 1'b1;
                end
            end
            DROP_PACKET: begin
                if (!pkt_valid) w_next = DECODE_ADDRESS;
            end
            default: w_next = DECODE_ADDRESS;
        endcase

        // A soft reset of the active channel aborts the packet without counting it.
        if (r_state != DECODE_ADDRESS && w_soft_hit) begin
            w_next     = DECODE_ADDRESS;
            w_timeout  = 1'b0;
            w_pkt_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= DECODE_ADDRESS;
            r_wait_cnt   <= 8'd0;
            addr_q       <= '0;
            pkt_count    <= 16'd0;
            wait_timeout <= 1'b0;
            detect_add   <= 1'b1;
            lfd_state    <= 1'b0;
            ld_state     <= 1'b0;
            laf_state    <= 1'b0;
            full_state   <= 1'b0;
            drop_state   <= 1'b0;
            wr_en_reg    <= 1'b0;
            rst_in_reg   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE_ADDRESS && w_next != DECODE_ADDRESS) begin
                addr_q <= w_din_addr;
            end
            if (r_state == WAIT_TILL_EMPTY && w_next == WAIT_TILL_EMPTY) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end else begin
                r_wait_cnt <= 8'd0;
            end
            if (w_pkt_done && pkt_count != 16'hFFFF) begin
                pkt_count <= pkt_count + 16'd1;
            end
            wait_timeout <= w_timeout;
            // Flags are registered from the next state so they track r_state exactly.
            detect_add   <= (w_next == DECODE_ADDRESS);
            lfd_state    <= (w_next == LOAD_FIRST_DATA);
            ld_state     <= (w_next == LOAD_DATA);
            laf_state    <= (w_next == LOAD_AFTER_FULL);
            full_state   <= (w_next == FIFO_FULL_STATE);
            drop_state   <= (w_next == DROP_PACKET);
            wr_en_reg    <= (w_next == LOAD_DATA) || (w_next == LOAD_AFTER_FULL) ||
                            (w_next == LOAD_PARITY);
            rst_in_reg   <= (w_next == CHECK_PARITY_ERROR);
            busy         <= (w_next == LOAD_FIRST_DATA) || (w_next == FIFO_FULL_STATE) ||
                            (w_next == LOAD_AFTER_FULL) || (w_next == LOAD_PARITY) ||
                            (w_next == CHECK_PARITY_ERROR) || (w_next == WAIT_TILL_EMPTY);
        end
    end

endmodule
`default_nettype wire
